// File: rtl/hilo_seq.sv
// hilo_seq -- HI/LO multiply/divide sequencer.
//
// Runs 32-cycle shift-add multiplies and restoring divides on operand
// magnitudes, applies a one-cycle sign fix-up, then writes the architectural
// HI/LO registers. MTHI/MTLO write HI/LO directly from IDLE.
//
// Optional feature macro: HILO_DIVZERO_FLAG_EN
//   defined   -> DIV by zero skips RUN, leaves HI/LO untouched, pulses div_zero
//   undefined -> DIV by zero runs normally and yields the natural restoring result
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request strobe (accepted only in IDLE)
//   op        in   00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//   sign      in   1 = signed operands (MULT/DIV)
//   A, B      in   32-bit operands
//   busy      out  MULT/DIV in progress
//   done      out  one-cycle completion pulse
//   outHI     out  HI register
//   outLO     out  LO register
//   div_zero  out  divide-by-zero pulse (only with HILO_DIVZERO_FLAG_EN)
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here
// RUN   | 32 iterations, one quotient/product bit per cycle
// FIX   | sign correction and HI/LO write
module hilo_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        sign,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] outHI,
    output logic [31:0] outLO
`ifdef HILO_DIVZERO_FLAG_EN
    ,
    output logic        div_zero
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // product / quotient negate
    logic        neg_rem_q, neg_rem_d;   // remainder takes dividend sign
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] bmag_q, bmag_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
`ifdef HILO_DIVZERO_FLAG_EN
    logic        dz_pend_q, dz_pend_d;
    logic        dz_q, dz_d;
`endif

    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] prod_raw;

    // Unsigned magnitude; 0x80000000 maps to itself, which is the correct
    // 2^31 magnitude when read as unsigned.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        // Shift-add: acc_lo holds the multiplier, shifted out LSB first.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, bmag_q} : 33'd0);
        // Restoring divide: acc_hi is the partial remainder, acc_lo the
        // dividend shifting out MSB first while quotient bits shift in.
        div_trial = {acc_hi_q, acc_lo_q[31]};
        div_ge    = (div_trial >= {1'b0, bmag_q});
        // When div_ge holds, trial - divisor < divisor, so 32 bits suffice.
        div_diff  = div_trial[31:0] - bmag_q;
        prod_raw  = {acc_hi_q, acc_lo_q};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        bmag_d    = bmag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef HILO_DIVZERO_FLAG_EN
        dz_pend_d = dz_pend_q;
        dz_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MTHI) begin
                        hi_d   = A;
                        done_d = 1'b1;
                    end else if (op == OP_MTLO) begin
                        lo_d   = A;
                        done_d = 1'b1;
                    end else begin
                        is_div_d  = (op == OP_DIV);
                        neg_res_d = sign & (A[31] ^ B[31]);
                        neg_rem_d = sign & A[31];
                        acc_hi_d  = 32'd0;
                        acc_lo_d  = mag(A, sign);
                        bmag_d    = mag(B, sign);
                        cnt_d     = 5'd31;
                        state_d   = S_RUN;
`ifdef HILO_DIVZERO_FLAG_EN
                        if (op == OP_DIV && B == 32'd0) begin
                            dz_pend_d = 1'b1;
                            state_d   = S_FIX;
                        end
`endif
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff : div_trial[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ge};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[31:1]};
                end
                if (cnt_q == 5'd0) state_d = S_FIX;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef HILO_DIVZERO_FLAG_EN
                dz_d      = dz_pend_q;
                dz_pend_d = 1'b0;
                if (!dz_pend_q) begin
`else
                begin
`endif
                    if (is_div_q) begin
                        lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                        hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? -prod_raw : prod_raw;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            bmag_q    <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
`ifdef HILO_DIVZERO_FLAG_EN
            dz_pend_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            bmag_q    <= bmag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef HILO_DIVZERO_FLAG_EN
            dz_pend_q <= dz_pend_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign outHI = hi_q;
    assign outLO = lo_q;
`ifdef HILO_DIVZERO_FLAG_EN
    assign div_zero = dz_q;
`endif

endmodule
